// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  localparam logic [31:0] DEFAULT_TERM_WORD = 32'hFFFF_FFFF;

  // Width of a counter that must reach limit-1 before wrapping back to zero.
  function automatic int unsigned tmo_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/uart_word_assembler.sv
// Packs UART bytes little-endian into 32-bit words, with break, timeout and
// disable flushing of a partially received word.
module uart_word_assembler
  import loader_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_break,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int unsigned TMO_W = tmo_width(BYTE_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BYTE_TIMEOUT - 1);

  logic [1:0]       byte_cnt;
  logic [23:0]      partial;
  logic [TMO_W-1:0] tmo_cnt;
  logic             take;

  // A byte is taken only while enabled and not overridden by a break.
  always_comb begin
    take       = accept && rx_valid && !rx_break;
    word_valid = take && (byte_cnt == 2'd3);
    word       = {rx_data, partial};
  end

  // Byte slotting, byte counter and inter-byte timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      partial  <= '0;
      tmo_cnt  <= '0;
    end else if (!accept || rx_break) begin
      byte_cnt <= '0;
      tmo_cnt  <= '0;
    end else if (take) begin
      case (byte_cnt)
        2'd0:    partial[7:0]   <= rx_data;
        2'd1:    partial[15:8]  <= rx_data;
        2'd2:    partial[23:16] <= rx_data;
        default: ;
      endcase
      byte_cnt <= byte_cnt + 2'd1;
      tmo_cnt  <= '0;
    end else if (byte_cnt != 2'd0) begin
      if (tmo_cnt == TMO_LAST) begin
        byte_cnt <= '0;
        tmo_cnt  <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: writes UART-received words to instruction memory from address
// 0 upward, holding the core in reset until a terminator or full memory.
module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter logic [31:0] TERM_WORD    = DEFAULT_TERM_WORD,
  parameter int unsigned BYTE_TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              write_done,
  output logic              core_rst,
  output logic              mem_full,
  output logic [ADDR_W:0]   word_count
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              word_valid;
  logic [31:0]       word;

  // The assembler keeps collecting during WRITE so a byte arriving then is kept.
  always_comb begin
    accept = load_en && ((state == COLLECT) || (state == WRITE));
  end

  uart_word_assembler #(
    .BYTE_TIMEOUT(BYTE_TIMEOUT)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_break  (rx_break),
    .word_valid(word_valid),
    .word      (word)
  );

  // Next-state and write strobe.
  always_comb begin
    state_nxt = state;
    imem_we   = 1'b0;
    case (state)
      IDLE: begin
        if (load_en) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (!load_en)                state_nxt = IDLE;
        else if (word_valid)         state_nxt = (word == TERM_WORD) ? DONE : WRITE;
      end
      WRITE: begin
        imem_we = 1'b1;
        if (ptr == '1)               state_nxt = DONE;
        else if (!load_en)           state_nxt = IDLE;
        else                         state_nxt = COLLECT;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Write port registers, word pointer and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      write_done <= 1'b0;
      core_rst   <= 1'b1;
      mem_full   <= 1'b0;
    end else begin
      if (word_valid && (word != TERM_WORD)) begin
        imem_addr  <= ptr;
        imem_wdata <= word;
      end
      if (state == WRITE) begin
        ptr        <= ptr + 1'b1;
        word_count <= word_count + 1'b1;
        if (ptr == '1) mem_full <= 1'b1;
      end
      if ((state_nxt == DONE) && (state != DONE)) begin
        write_done <= 1'b1;
        core_rst   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- Boot-time program loader between the UART receiver and the instruction memory of the RISC-V core.
- Assembles received UART bytes into 32-bit little-endian instruction words and writes them to consecutive instruction-memory addresses starting at 0.
- Detects a terminator word, then asserts write_done and releases the core from reset.
- Holds the core in reset for the whole load; owns the imem write port until the load finishes.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words.
- TERM_WORD, 32'hFFFF_FFFF, end-of-program marker; it is never written to memory.
- BYTE_TIMEOUT, 1_000_000, clk cycles allowed between bytes of one word before the partial word is discarded.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- load_en  in  1  loader enable (driven by uart_rx_en).
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  in  8  received byte.
- rx_break  in  1  one-cycle pulse: UART BREAK detected.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  write data.
- write_done  out  1  load complete (sticky).
- core_rst  out  1  reset to the CPU core; held high until the load completes.
- mem_full  out  1  load ended because capacity was reached, not because TERM_WORD arrived.
- word_count  out  ADDR_W+1  number of words written.

Behaviour:
- Reset (async, rst=1) forces IDLE. All outputs are 0 except core_rst=1. byte_cnt, word pointer and timeout counter all clear.
- States:
  - IDLE: bytes ignored. load_en=1 moves to COLLECT on the next clk.
  - COLLECT: accept bytes and assemble words.
  - WRITE: exactly one cycle; performs the memory write.
  - DONE: terminal until rst.
- Byte assembly:
  - On rx_valid in COLLECT, the byte goes to slot byte_cnt: first byte into [7:0], fourth into [31:24]. byte_cnt then increments modulo 4.
  - On the 4th byte the completed word is latched into the word register.
  - If word != TERM_WORD, go to WRITE. If word == TERM_WORD, go to DONE.
- WRITE:
  - imem_we=1 for exactly one cycle, in the cycle after the 4th byte's rx_valid.
  - imem_addr = word pointer; imem_wdata = latched word.
  - Pointer and word_count increment at the end of the cycle.
  - If the address written was 2^ADDR_W-1, go to DONE with mem_full=1; otherwise return to COLLECT.
  - An rx_valid arriving during WRITE is captured into slot 0 of the next word (the assembly register is separate from the write register).
- DONE:
  - write_done=1 and core_rst=0 from the cycle after entry.
  - imem_we stays 0; rx_valid and rx_break are ignored.
  - Only rst leaves DONE.
- rx_break in COLLECT: discard the partial word (byte_cnt=0); pointer unchanged.
- If rx_break and rx_valid occur in the same cycle, the break wins and the byte is dropped.
- Timeout:
  - Counter runs only while byte_cnt != 0 and clears on every accepted byte.
  - Reaching BYTE_TIMEOUT discards the partial word (byte_cnt=0) and clears the counter.
- load_en falls in COLLECT: go to IDLE and discard the partial word; pointer and word_count are kept, so the load resumes when load_en returns.
- load_en falls in WRITE: the write still completes, then go to IDLE.
- imem_addr and imem_wdata are registered; imem_we is never high in two consecutive cycles.

Decomposition:
- Shared package (loader_pkg): state enum {IDLE, COLLECT, WRITE, DONE}, default TERM_WORD, and a clog2-based width constant for the timeout counter.
- One sub-module: uart_word_assembler. It contains the byte slotting, byte_cnt, timeout counter and break/flush handling, and outputs word_valid pulse + word.
- The top-level loader holds the FSM, pointer and status outputs.

Test Plan:
- Bytes 13 01 01 FE, 23 2E 81 00, then FF FF FF FF:
  - writes (addr 0, FE010113) and (addr 1, 00812E23), each as a one-cycle imem_we in the cycle after the 4th byte.
  - No write for the terminator.
  - write_done=1 and core_rst=0 one cycle after the last FF; word_count=2; mem_full=0.
- Bytes AA BB, then rx_break, then 11 22 33 44 -> single write of 44332211 at addr 0; AA/BB never appear in memory.
- BYTE_TIMEOUT=100: bytes 01 02, idle 150 cycles, then 05 06 07 08 -> single write 08070605 at addr 0.
- ADDR_W=2: five words 1..5 (no terminator):
  - writes at addr 0..3 only.
  - DONE with mem_full=1, write_done=1, word_count=4.
  - 5th word produces no imem_we.
- load_en dropped after one word plus 2 bytes, then restored, then 4 bytes -> second write at addr 1 containing only the new 4 bytes.
- rst pulsed mid-word and after DONE:
  - core_rst returns to 1 and write_done to 0 immediately (asynchronously).
  - the next full word writes to addr 0.
